// File: rtl/queue_pkg.sv
// queue_pkg: shared constants and helpers for the queue FIFO.
//   QUEUE_DEFAULT_WIDTH / QUEUE_DEFAULT_DEPTH : default parameter values
//   queue_ptr_width()                         : pointer width for a given depth
package queue_pkg;

    localparam int unsigned QUEUE_DEFAULT_WIDTH = 8;
    localparam int unsigned QUEUE_DEFAULT_DEPTH = 8;

    // Smallest w with 2**w >= depth. For a power-of-two depth this is log2.
    function automatic int unsigned queue_ptr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/queue_if.sv
// queue_if: request/status bundle between a queue and its user.
//   push, pop, data_in       : requests from the user (master)
//   data_out, empty, full,
//   count                    : registered results from the queue (slave)
//   clear_err, overflow,
//   underflow                : sticky error handling, present only when
//                              QUEUE_ERR_EN is defined
interface queue_if
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH = QUEUE_DEFAULT_WIDTH,
    parameter int unsigned DEPTH = QUEUE_DEFAULT_DEPTH
);
    localparam int unsigned AW = queue_ptr_width(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
`ifdef QUEUE_ERR_EN
    logic             clear_err;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, data_in, clear_err,
        input  data_out, empty, full, count, overflow, underflow
    );
    modport slave (
        input  push, pop, data_in, clear_err,
        output data_out, empty, full, count, overflow, underflow
    );
`else
    modport master (
        output push, pop, data_in,
        input  data_out, empty, full, count
    );
    modport slave (
        input  push, pop, data_in,
        output data_out, empty, full, count
    );
`endif

endinterface

// File: rtl/queue_mem.sv
// queue_mem: DEPTH x WIDTH register array for the queue.
//   clk, rst_n    : clock and asynchronous active-low reset (read register only)
//   we/waddr/wdata: synchronous write port
//   re/raddr/rdata: synchronous read port; rdata holds until the next re
// Array contents are not reset.
module queue_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the pre-edge contents, so a same-address write and read
    // on a full queue returns the old (oldest) word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/queue.sv
// queue: single-clock register-array FIFO.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   q       : queue_if.slave -- push/pop/data_in in; data_out/empty/full/count
//             out (all registered); with QUEUE_ERR_EN defined also clear_err in
//             and sticky overflow/underflow out.
// Build option: QUEUE_ERR_EN enables the sticky error flags.
module queue
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH = QUEUE_DEFAULT_WIDTH,
    parameter int unsigned DEPTH = QUEUE_DEFAULT_DEPTH
) (
    input  logic   clk,
    input  logic   reset_n,
    queue_if.slave q
);
    localparam int unsigned AW = queue_ptr_width(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt;
    logic          empty_r;
    logic          full_r;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full queue is accepted when a pop frees a slot that edge.
    assign pop_ok  = q.pop && !empty_r;
    assign push_ok = q.push && (!full_r || pop_ok);

    always_comb begin
        count_nxt = count_r;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_r + (AW + 1)'(1);
            2'b01:   count_nxt = count_r - (AW + 1)'(1);
            default: count_nxt = count_r;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_r <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == COUNT_FULL);
        end
    end

    assign q.count = count_r;
    assign q.empty = empty_r;
    assign q.full  = full_r;

    queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (q.data_in),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (q.data_out)
    );

`ifdef QUEUE_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // clear_err wins over a set in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (q.clear_err) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (q.push && !push_ok) begin
                overflow_r <= 1'b1;
            end
            if (q.pop && !pop_ok) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign q.overflow  = overflow_r;
    assign q.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_queue.sv
module tb_queue;
    import queue_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic reset_n;

    int unsigned n_tests;
    int unsigned n_fail;

    queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) qif ();

    queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, release and sample 1ns after the posedge.
    task automatic cycle(input logic p, input logic o, input logic [WIDTH-1:0] d, input logic clr);
        @(negedge clk);
        qif.push    = p;
        qif.pop     = o;
        qif.data_in = d;
`ifdef QUEUE_ERR_EN
        qif.clear_err = clr;
`else
        if (clr) begin end
`endif
        @(posedge clk);
        #1;
        qif.push    = 1'b0;
        qif.pop     = 1'b0;
`ifdef QUEUE_ERR_EN
        qif.clear_err = 1'b0;
`endif
    endtask

    task automatic check_status(input string tag, input int unsigned cnt);
        check({tag, ".count"}, 32'(qif.count), 32'(cnt));
        check({tag, ".empty"}, 32'(qif.empty), 32'(cnt == 0));
        check({tag, ".full"},  32'(qif.full),  32'(cnt == DEPTH));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n     = 1'b0;
        qif.push    = 1'b0;
        qif.pop     = 1'b0;
        qif.data_in = '0;
`ifdef QUEUE_ERR_EN
        qif.clear_err = 1'b0;
`endif
        #12;
        check_status("rst", 0);
        check("rst.data_out", 32'(qif.data_out), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 0, 8'h00, 0);
        check_status("idle", 0);
        check("idle.data_out", 32'(qif.data_out), 32'h00);
`ifdef QUEUE_ERR_EN
        check("idle.overflow",  32'(qif.overflow),  0);
        check("idle.underflow", 32'(qif.underflow), 0);
`endif

        // Three in, three out, arrival order.
        cycle(1, 0, 8'h11, 0);
        check_status("p1", 1);
        cycle(1, 0, 8'h22, 0);
        cycle(1, 0, 8'h33, 0);
        check_status("p3", 3);
        cycle(0, 1, 8'h00, 0);
        check("pop1", 32'(qif.data_out), 32'h11);
        cycle(0, 1, 8'h00, 0);
        check("pop2", 32'(qif.data_out), 32'h22);
        cycle(0, 1, 8'h00, 0);
        check("pop3", 32'(qif.data_out), 32'h33);
        check_status("pop3", 0);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'(i), 0);
        check_status("fill", 8);
        cycle(1, 0, 8'hAA, 0);
        check_status("ovf", 8);
        check("ovf.data_out", 32'(qif.data_out), 32'h33);
`ifdef QUEUE_ERR_EN
        check("ovf.flag", 32'(qif.overflow), 1);
        cycle(0, 0, 8'h00, 1);
        check("ovf.clr", 32'(qif.overflow), 0);
`endif
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 8'h00, 0);
            check($sformatf("drain%0d", i), 32'(qif.data_out), 32'(i));
        end
        check_status("drained", 0);

        // Push and pop together on a full queue.
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'(i), 0);
        cycle(1, 1, 8'h55, 0);
        check("pp_full.data_out", 32'(qif.data_out), 32'h00);
        check_status("pp_full", 8);
`ifdef QUEUE_ERR_EN
        check("pp_full.overflow", 32'(qif.overflow), 0);
`endif
        for (int i = 1; i < 8; i++) begin
            cycle(0, 1, 8'h00, 0);
            check($sformatf("pp_drain%0d", i), 32'(qif.data_out), 32'(i));
        end
        cycle(0, 1, 8'h00, 0);
        check("pp_last", 32'(qif.data_out), 32'h55);
        check_status("pp_last", 0);

        // Underflow: data_out holds.
        cycle(0, 1, 8'h00, 0);
        check("udf.data_out", 32'(qif.data_out), 32'h55);
        check_status("udf", 0);
`ifdef QUEUE_ERR_EN
        check("udf.flag", 32'(qif.underflow), 1);
        cycle(0, 0, 8'h00, 1);
        check("udf.clr", 32'(qif.underflow), 0);
        // Clear beats a simultaneous set.
        cycle(0, 1, 8'h00, 1);
        check("udf.clr_prio", 32'(qif.underflow), 0);
`endif

        // Push + pop on empty: push accepted, pop rejected, no fall-through.
        cycle(1, 1, 8'h77, 0);
        check("pp_empty.data_out", 32'(qif.data_out), 32'h55);
        check_status("pp_empty", 1);
        cycle(0, 1, 8'h00, 0);
        check("pp_empty.pop", 32'(qif.data_out), 32'h77);
        check_status("pp_empty.pop", 0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h10 + i), 0);
        check_status("pre_rst", 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_status("arst", 0);
        check("arst.data_out", 32'(qif.data_out), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 1, 8'h00, 0);
        check("post_rst.data_out", 32'(qif.data_out), 32'h00);
        check_status("post_rst", 0);
`ifdef QUEUE_ERR_EN
        check("post_rst.underflow", 32'(qif.underflow), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
